// File: rtl/wordle_pkg.sv
// Shared definitions for the Wordle scoring datapath.
//   - Tile color encodings (gray / yellow / green)
//   - Word geometry (letters per word, rows in the grid)
//   - Scorer state encoding
//   - letter_at(): selects one 8-bit letter out of a packed 5-letter word
package wordle_pkg;

  localparam int N_LETTERS = 5;
  localparam int N_ROWS    = 6;

  localparam logic [1:0] COLOR_GRAY   = 2'b00;
  localparam logic [1:0] COLOR_YELLOW = 2'b01;
  localparam logic [1:0] COLOR_GREEN  = 2'b10;

  // Highest letter index; every counter wraps from here back to 0.
  localparam logic [2:0] LAST_IDX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Letter 0 sits in the top byte of the packed word, letter 4 in the bottom.
  function automatic logic [7:0] letter_at(input logic [39:0] word,
                                           input logic [2:0]  idx);
    logic [7:0] sel;
    case (idx)
      3'd0:    sel = word[39:32];
      3'd1:    sel = word[31:24];
      3'd2:    sel = word[23:16];
      3'd3:    sel = word[15:8];
      3'd4:    sel = word[7:0];
      default: sel = 8'd0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wordle_guess_scorer.sv
// Sequential Wordle guess scorer.
// Latches a guess/answer/row on start, scores the guess with a green pass
// (5 cycles) and a duplicate-aware yellow pass (25 cycles) through one shared
// 8-bit comparator, streams the five tiles into the tile memory (5 cycles),
// then pulses done and publishes colors/win.
// Ports:
//   Clk, reset_n          clock, async active-low reset
//   start, guess, answer, row   scoring request from the guess state machine
//   busy, done, err       status (done/err are one-cycle pulses)
//   colors, win           result of the last completed scoring, held
//   wr_en, wr_row, wr_col, wr_char, wr_color   tile-memory write port
module wordle_guess_scorer
  import wordle_pkg::*;
#(
  parameter int N_ROWS = wordle_pkg::N_ROWS
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [39:0] guess,
  input  logic [39:0] answer,
  input  logic [2:0]  row,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  colors,
  output logic        win,
  output logic        wr_en,
  output logic [2:0]  wr_row,
  output logic [2:0]  wr_col,
  output logic [7:0]  wr_char,
  output logic [1:0]  wr_color
);

  // Extra bit so that N_ROWS = 8 still compares correctly against a 3-bit row.
  localparam logic [3:0] ROW_LIMIT = 4'(N_ROWS);

  state_t      state_r;
  logic [39:0] guess_r;
  logic [39:0] answer_r;
  logic [2:0]  row_r;
  logic [4:0]  used_r;
  logic [1:0]  color_r [N_LETTERS];
  logic [2:0]  i_r;
  logic [2:0]  j_r;

  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [9:0]  colors_r;
  logic        win_r;
  logic        wr_en_r;
  logic [2:0]  wr_row_r;
  logic [2:0]  wr_col_r;
  logic [7:0]  wr_char_r;
  logic [1:0]  wr_color_r;

  logic [7:0]  cmp_guess_s;
  logic [7:0]  cmp_answer_s;
  logic        match_s;
  logic [9:0]  colors_pack_s;
  logic        win_pack_s;
  logic        yellow_hit_s;

  // Shared letter comparator: the guess side always follows i, the answer
  // side follows i during the green pass and j during the yellow pass.
  always_comb begin
    cmp_guess_s = letter_at(guess_r, i_r);
    if (state_r == ST_GREEN) begin
      cmp_answer_s = letter_at(answer_r, i_r);
    end else begin
      cmp_answer_s = letter_at(answer_r, j_r);
    end
    match_s = (cmp_guess_s == cmp_answer_s);
  end

  // Yellow candidate: letter i still gray, answer slot j not yet claimed.
  always_comb begin
    if ((color_r[i_r] == COLOR_GRAY) && !used_r[j_r] && match_s) begin
      yellow_hit_s = 1'b1;
    end else begin
      yellow_hit_s = 1'b0;
    end
  end

  // Packed view of the internal colors for publishing in DONE.
  always_comb begin
    colors_pack_s = {color_r[0], color_r[1], color_r[2], color_r[3], color_r[4]};
    win_pack_s    = (colors_pack_s == {COLOR_GREEN, COLOR_GREEN, COLOR_GREEN,
                                       COLOR_GREEN, COLOR_GREEN});
  end

  // Scoring FSM with all outputs registered.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      guess_r    <= 40'd0;
      answer_r   <= 40'd0;
      row_r      <= 3'd0;
      used_r     <= 5'd0;
      for (int k = 0; k < N_LETTERS; k++) color_r[k] <= COLOR_GRAY;
      i_r        <= 3'd0;
      j_r        <= 3'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      colors_r   <= 10'd0;
      win_r      <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_row_r   <= 3'd0;
      wr_col_r   <= 3'd0;
      wr_char_r  <= 8'd0;
      wr_color_r <= COLOR_GRAY;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if ({1'b0, row} < ROW_LIMIT) begin
              guess_r  <= guess;
              answer_r <= answer;
              row_r    <= row;
              used_r   <= 5'd0;
              for (int k = 0; k < N_LETTERS; k++) color_r[k] <= COLOR_GRAY;
              i_r      <= 3'd0;
              j_r      <= 3'd0;
              busy_r   <= 1'b1;
              state_r  <= ST_GREEN;
            end else begin
              err_r <= 1'b1;
            end
          end
        end

        ST_GREEN: begin
          if (match_s) begin
            color_r[i_r] <= COLOR_GREEN;
            used_r[i_r]  <= 1'b1;
          end
          if (i_r == LAST_IDX) begin
            i_r     <= 3'd0;
            state_r <= ST_YELLOW;
          end else begin
            i_r <= i_r + 3'd1;
          end
        end

        // Always a full 5x5 sweep; once letter i turns yellow the
        // gray check in yellow_hit_s blocks further claims for that i.
        ST_YELLOW: begin
          if (yellow_hit_s) begin
            color_r[i_r] <= COLOR_YELLOW;
            used_r[j_r]  <= 1'b1;
          end
          if (j_r == LAST_IDX) begin
            j_r <= 3'd0;
            if (i_r == LAST_IDX) begin
              // Preload column 0 so the write strobe starts with WRITE.
              // color_r[0] is already final here.
              i_r        <= 3'd0;
              state_r    <= ST_WRITE;
              wr_en_r    <= 1'b1;
              wr_row_r   <= row_r;
              wr_col_r   <= 3'd0;
              wr_char_r  <= letter_at(guess_r, 3'd0);
              wr_color_r <= color_r[0];
            end else begin
              i_r <= i_r + 3'd1;
            end
          end else begin
            j_r <= j_r + 3'd1;
          end
        end

        // The write port shows column i; load column i+1 for the next cycle.
        ST_WRITE: begin
          if (i_r == LAST_IDX) begin
            i_r      <= 3'd0;
            wr_en_r  <= 1'b0;
            done_r   <= 1'b1;
            colors_r <= colors_pack_s;
            win_r    <= win_pack_s;
            state_r  <= ST_DONE;
          end else begin
            i_r        <= i_r + 3'd1;
            wr_col_r   <= i_r + 3'd1;
            wr_char_r  <= letter_at(guess_r, i_r + 3'd1);
            wr_color_r <= color_r[i_r + 3'd1];
          end
        end

        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          busy_r  <= 1'b0;
          wr_en_r <= 1'b0;
          i_r     <= 3'd0;
          j_r     <= 3'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign colors   = colors_r;
  assign win      = win_r;
  assign wr_en    = wr_en_r;
  assign wr_row   = wr_row_r;
  assign wr_col   = wr_col_r;
  assign wr_char  = wr_char_r;
  assign wr_color = wr_color_r;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Self-checking bench for wordle_guess_scorer: directed cases plus random
// guesses over a small alphabet (to force duplicate letters), checked against
// a letter-count reference model of Wordle scoring.
module tb_wordle_guess_scorer;

  logic        Clk;
  logic        reset_n;
  logic        start;
  logic [39:0] guess;
  logic [39:0] answer;
  logic [2:0]  row;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  colors;
  logic        win;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [2:0]  wr_col;
  logic [7:0]  wr_char;
  logic [1:0]  wr_color;

  int          cmp_count;
  int          err_count;
  logic [9:0]  last_colors;
  logic        last_win;

  wordle_guess_scorer #(.N_ROWS(6)) dut (
    .Clk(Clk), .reset_n(reset_n), .start(start), .guess(guess),
    .answer(answer), .row(row), .busy(busy), .done(done), .err(err),
    .colors(colors), .win(win), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_char(wr_char), .wr_color(wr_color)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wordle scoring from letter counts: greens first, then each remaining
  // guess letter (left to right) takes one unmatched answer letter if any.
  function automatic logic [9:0] model_colors(input logic [39:0] g, input logic [39:0] a);
    int         cnt [256];
    logic [7:0] gl [5];
    logic [7:0] al [5];
    logic [1:0] c [5];
    logic [9:0] res;
    for (int k = 0; k < 256; k++) cnt[k] = 0;
    for (int k = 0; k < 5; k++) begin
      gl[k] = g[39-8*k -: 8];
      al[k] = a[39-8*k -: 8];
    end
    for (int k = 0; k < 5; k++) begin
      if (gl[k] == al[k]) c[k] = 2'b10;
      else begin
        c[k] = 2'b00;
        cnt[al[k]]++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (c[k] != 2'b10 && cnt[gl[k]] > 0) begin
        c[k] = 2'b01;
        cnt[gl[k]]--;
      end
    end
    res = {c[0], c[1], c[2], c[3], c[4]};
    return res;
  endfunction

  // One full scoring; optional stray start during cycle 10.
  task automatic run_score(input logic [39:0] g, input logic [39:0] a,
                           input logic [2:0] r, input bit poke, input string tag);
    logic [9:0] exp_c;
    logic       exp_w;
    int busy_bad, done_cnt, done_cyc, wr_cnt, wr_bad, col;
    logic [9:0] col36;
    logic       win36;
    exp_c = model_colors(g, a);
    exp_w = (exp_c == 10'b10_10_10_10_10);
    busy_bad = 0; done_cnt = 0; done_cyc = 0; wr_cnt = 0; wr_bad = 0;
    col36 = 10'd0; win36 = 1'b0;
    @(negedge Clk);
    guess = g; answer = a; row = r; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    check({tag, " held_colors"}, colors, last_colors);
    for (int k = 1; k <= 37; k++) begin
      if (poke && k == 10) begin start = 1'b1; guess = ~g; row = 3'd1; end
      if (poke && k == 11) begin start = 1'b0; guess = g; row = r; end
      if (busy !== (k <= 36)) busy_bad++;
      if (done === 1'b1) begin done_cnt++; done_cyc = k; end
      if (wr_en === 1'b1) begin
        wr_cnt++;
        if (k < 31 || k > 35) wr_bad++;
        else begin
          col = k - 31;
          if (wr_row !== r || wr_col !== col[2:0] ||
              wr_char !== g[39-8*col -: 8] || wr_color !== exp_c[9-2*col -: 2])
            wr_bad++;
        end
      end
      if (k == 36) begin col36 = colors; win36 = win; end
      @(posedge Clk); #1;
    end
    check({tag, " busy_window"}, busy_bad, 0);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_cycle"}, done_cyc, 36);
    check({tag, " wr_count"}, wr_cnt, 5);
    check({tag, " wr_content"}, wr_bad, 0);
    check({tag, " colors"}, col36, exp_c);
    check({tag, " win"}, win36, exp_w);
    check({tag, " colors_hold"}, colors, exp_c);
    last_colors = exp_c;
    last_win    = exp_w;
  endtask

  initial begin
    logic [39:0] rg, ra;
    int          wr_seen;
    cmp_count = 0; err_count = 0;
    last_colors = 10'd0; last_win = 1'b0;
    reset_n = 1'b0; start = 1'b0; guess = 40'd0; answer = 40'd0; row = 3'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst colors", colors, 10'd0);
    check("rst win", win, 1'b0);
    check("rst wr", {wr_en, wr_row, wr_col, wr_char, wr_color}, 17'd0);
    @(negedge Clk); reset_n = 1'b1;

    // Directed cases with fixed expected colors.
    run_score("CRANE", "CRANE", 3'd0, 1'b0, "crane");
    check("crane spec_colors", colors, 10'b10_10_10_10_10);
    check("crane spec_win", win, 1'b1);
    run_score("BABES", "ABBEY", 3'd1, 1'b0, "babes");
    check("babes spec_colors", colors, 10'b01_01_10_10_00);
    check("babes spec_win", win, 1'b0);
    run_score("PAPPY", "APPLE", 3'd5, 1'b0, "pappy");
    check("pappy spec_colors", colors, 10'b01_01_10_00_00);

    // Out-of-range row is rejected with an err pulse.
    @(negedge Clk); row = 3'd6; start = 1'b1; guess = "ZZZZZ"; answer = "ZZZZZ";
    @(posedge Clk); #1; start = 1'b0;
    check("err pulse", err, 1'b1);
    check("err busy", busy, 1'b0);
    wr_seen = 0;
    @(posedge Clk); #1;
    check("err cleared", err, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (wr_en === 1'b1 || busy === 1'b1) wr_seen++;
      @(posedge Clk); #1;
    end
    check("err no_activity", wr_seen, 0);
    check("err colors_kept", colors, last_colors);

    // Row 7 as well.
    @(negedge Clk); row = 3'd7; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    check("err7 pulse", err, 1'b1);

    // Stray start while busy is ignored.
    run_score("SLATE", "STEAL", 3'd2, 1'b1, "poke");

    // Reset during the yellow pass.
    @(negedge Clk); guess = "LEVEL"; answer = "HELLO"; row = 3'd3; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    repeat (19) begin @(posedge Clk); #1; end
    reset_n = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst outs", {done, err, colors, win}, 13'd0);
    check("midrst wr", {wr_en, wr_row, wr_col, wr_char, wr_color}, 17'd0);
    last_colors = 10'd0; last_win = 1'b0;
    @(negedge Clk); reset_n = 1'b1;
    run_score("LEVEL", "HELLO", 3'd3, 1'b0, "after_rst");

    // Random guesses over a four-letter alphabet.
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 5; k++) begin
        rg[39-8*k -: 8] = 8'h41 + 8'($urandom_range(0, 3));
        ra[39-8*k -: 8] = 8'h41 + 8'($urandom_range(0, 3));
      end
      if (t % 7 == 0) ra = rg;
      run_score(rg, ra, 3'($urandom_range(0, 5)), 1'b0, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/wordle_guess_scorer.md
# wordle_guess_scorer

Sequential scoring controller for the Wordle datapath. On a submitted guess it latches the five guess letters and the hidden answer, runs a green pass and a duplicate-aware yellow pass over a single shared 8-bit letter comparator, and writes the five scored tiles into the display tile memory that the VGA renderer reads. It sits between the guess state machine, which supplies the guess, answer and row, and the tile memory.

## Interface
Parameters:
- `N_ROWS`, 6: number of guess rows; legal `row` values are 0..N_ROWS-1.

Ports:
- `Clk`, in, 1: system clock; all logic on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request to score; sampled only in IDLE.
- `guess`, in, 40: five ASCII letters; letter 0 is [39:32], letter 4 is [7:0].
- `answer`, in, 40: hidden word, same packing as `guess`.
- `row`, in, 3: grid row for this guess.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse when scoring completes.
- `err`, out, 1: one-cycle pulse when `start` is rejected for `row` ≥ N_ROWS.
- `colors`, out, 10: per-letter result; letter 0 is [9:8]. Encoding: 00 gray, 01 yellow, 10 green.
- `win`, out, 1: high when all five letters are green; updates with `done`.
- `wr_en`, out, 1: tile-memory write strobe.
- `wr_row`, out, 3: write row address.
- `wr_col`, out, 3: write column address, 0..4.
- `wr_char`, out, 8: ASCII character for the tile.
- `wr_color`, out, 2: color for the tile.

## Operation
States: IDLE → GREEN → YELLOW → WRITE → DONE → IDLE.

- **IDLE**
  - `start`=1 with `row` < N_ROWS: latch `guess`, `answer` and `row`; clear `used[4:0]` and the internal color registers to gray; go to GREEN.
  - `start`=1 with `row` ≥ N_ROWS: pulse `err` and stay in IDLE.
- **GREEN** (i = 0..4, one letter per cycle): if g[i] == a[i], set color[i] = green and used[i] = 1.
- **YELLOW** (i = 0..4 outer, j = 0..4 inner, one (i, j) pair per cycle, always 25 cycles):
  - Condition: color[i] is gray, used[j] == 0, and g[i] == a[j].
  - When true: set color[i] = yellow and used[j] = 1.
  - Once color[i] is non-gray, the remaining j for that i perform no update.
- **WRITE** (c = 0..4, one cycle each): `wr_en`=1, `wr_row`=latched row, `wr_col`=c, `wr_char`=g[c], `wr_color`=color[c].
- **DONE** (1 cycle): `done`=1; `colors` and `win` are loaded from the internal registers. Next state is IDLE.
- `colors` and `win` hold their values until the next DONE. They are not cleared by a new `start`.
- `start` while busy is ignored; no queueing.
- Letters are compared as raw 8-bit values. Case folding is the caller's responsibility.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `colors` 10'b0, `win` 0, `wr_en` 0, `wr_row` 0, `wr_col` 0, `wr_char` 0, `wr_color` 0, `used` 0, all counters 0.
- Fixed latency. `start` is sampled at edge 0. Then:
  - GREEN occupies cycles 1-5.
  - YELLOW occupies cycles 6-30.
  - WRITE occupies cycles 31-35.
  - `done` is high in cycle 36.
  - `busy` is high in cycles 1-36.
  - A new `start` is accepted at the earliest in cycle 37.
- `err` is asserted the cycle after the rejected `start`.
- Write-port outputs are registered; `wr_en` is high for exactly 5 consecutive cycles per scoring.
- If `reset_n` is asserted mid-operation, the block returns to its reset values immediately. A partially written row remains in tile memory; the owner of that memory must clear it.
- Counters are 3-bit and wrap 4 → 0 when advancing the outer or inner index. No counter reaches 5.

## Structure
- Shared package `wordle_pkg`:
  - Color encodings `COLOR_GRAY`, `COLOR_YELLOW`, `COLOR_GREEN`.
  - Constants `N_LETTERS`=5 and `N_ROWS`=6.
  - State encoding constants.
- No sub-module. A single comparator is muxed by the `i` and `j` indices. `used`, color registers and counters live in this module.

## Test plan
- Answer "CRANE", guess "CRANE", row 0, `start` pulse → `colors` = 10'b10_10_10_10_10, `win`=1, `done` in cycle 36, five writes to row 0 at cols 0..4 with chars C,R,A,N,E.
- Answer "ABBEY", guess "BABES" → `colors` = 01_01_10_10_00, `win`=0.
- Answer "APPLE", guess "PAPPY" (duplicate handling) → `colors` = 01_01_10_00_00. The second extra P must be gray.
- `start` with `row`=6 → `err` pulse the next cycle, `busy` stays 0, no `wr_en`, `colors` unchanged.
- `start` re-asserted in cycle 10 of an active scoring → ignored. Exactly one `done` and five writes occur.
- `reset_n` low in cycle 20 → all outputs reach reset values asynchronously. A `start` after release scores normally with full 36-cycle latency.
